// File: rtl/execution_mc.sv
// execution_mc: multi-cycle execute stage.
// ALU ops and branches resolve in the cycle they are presented. MUL runs through an
// iterative shift-add datapath. DIV/DIVU/REM/REMU run through a restoring shift-subtract
// datapath. Both hold the pipeline via hold_en until the result is written back.
// Optional feature macro: EXEC_MC_DIV_EN builds in the divider. Without it, DIV/DIVU/REM/REMU
// decode as unknown instructions.
//
// Handshake: an instruction is consumed in any IDLE cycle where in_valid=1. While hold_en=1,
// the upstream stage must keep inst/op1/op2 stable. The cycle after hold_en drops, the
// upstream stage may present the next instruction. In DONE, the held instruction is still
// present and is ignored.
module execution_mc #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] inst_addr,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_we,
    output logic [XLEN-1:0] jump_addr,
    output logic            jump_en,
    output logic            hold_en,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);

    state_t state, state_next;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       unused_fields;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    // Register specifiers are resolved upstream. Only operand values reach this stage.
    assign unused_fields = ^inst[24:15];

    logic is_addi, is_add, is_sub, is_branch, is_mop, br_taken;
    logic [12:0]     b_imm;
    logic [XLEN-1:0] br_target;

    assign is_addi   = (opcode == OPC_OP_IMM) && (funct3 == 3'b000);
    assign is_add    = (opcode == OPC_OP) && (funct3 == 3'b000) && (funct7 == F7_BASE);
    assign is_sub    = (opcode == OPC_OP) && (funct3 == 3'b000) && (funct7 == F7_SUB);
    assign is_branch = (opcode == OPC_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
`ifdef EXEC_MC_DIV_EN
    assign is_mop    = (opcode == OPC_OP) && (funct7 == F7_MULDIV) &&
                       ((funct3 == 3'b000) || funct3[2]);
`else
    assign is_mop    = (opcode == OPC_OP) && (funct7 == F7_MULDIV) && (funct3 == 3'b000);
`endif

    assign b_imm     = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign br_target = inst_addr + XLEN'(signed'(b_imm));

    // Branch condition evaluation
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (op1 == op2);
            3'b001:  br_taken = (op1 != op2);
            3'b100:  br_taken = ($signed(op1) <  $signed(op2));
            3'b101:  br_taken = ($signed(op1) >= $signed(op2));
            3'b110:  br_taken = (op1 <  op2);
            3'b111:  br_taken = (op1 >= op2);
            default: br_taken = 1'b0;
        endcase
    end

    // Iterative datapath registers.
    // acc: product (MUL) or partial remainder (DIV/REM).
    // a_q: multiplicand (MUL), or dividend shifting out while quotient bits shift in (DIV).
    // b_q: multiplier shifting out MSB-first (MUL), or divisor magnitude (DIV).
    logic [XLEN-1:0]  acc, a_q, b_q, result;
    logic [CNT_W-1:0] cnt;

`ifdef EXEC_MC_DIV_EN
    logic            is_mul_q, is_rem_q, neg_q;
    logic            signed_op, trial_ge;
    logic [XLEN-1:0] op1_mag, op2_mag, rem_sub;
    logic [XLEN:0]   trial;

    assign signed_op = (funct3 == 3'b100) || (funct3 == 3'b110);
    assign op1_mag   = (signed_op && op1[XLEN-1]) ? -op1 : op1;
    assign op2_mag   = (signed_op && op2[XLEN-1]) ? -op2 : op2;
    assign trial     = {acc, a_q[XLEN-1]};
    assign trial_ge  = (trial >= {1'b0, b_q});
    // Only used when trial >= divisor, so the difference always fits in XLEN bits.
    assign rem_sub   = trial[XLEN-1:0] - b_q;
    assign result    = is_mul_q ? acc :
                       is_rem_q ? (neg_q ? -acc : acc) :
                                  (neg_q ? -a_q : a_q);
`else
    assign result    = acc;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand capture on accept, and one multiply or divide step per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
`ifdef EXEC_MC_DIV_EN
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else if ((state == IDLE) && (state_next == CALC)) begin
            acc <= '0;
            cnt <= CNT_INIT;
`ifdef EXEC_MC_DIV_EN
            a_q      <= op1_mag;
            b_q      <= op2_mag;
            is_mul_q <= (funct3 == 3'b000);
            is_rem_q <= funct3[1];
            // A zero divisor keeps the all-ones quotient. The remainder follows the dividend.
            neg_q    <= funct3[1] ? (signed_op & op1[XLEN-1]) :
                        (signed_op & (op1[XLEN-1] ^ op2[XLEN-1]) & (op2 != '0));
`else
            a_q <= op1;
            b_q <= op2;
`endif
        end else if (state == CALC) begin
            cnt <= cnt - CNT_W'(1);
`ifdef EXEC_MC_DIV_EN
            if (is_mul_q) begin
                acc <= {acc[XLEN-2:0], 1'b0} + (b_q[XLEN-1] ? a_q : '0);
                b_q <= {b_q[XLEN-2:0], 1'b0};
            end else begin
                acc <= trial_ge ? rem_sub : trial[XLEN-1:0];
                a_q <= {a_q[XLEN-2:0], trial_ge};
            end
`else
            acc <= {acc[XLEN-2:0], 1'b0} + (b_q[XLEN-1] ? a_q : '0);
            b_q <= {b_q[XLEN-2:0], 1'b0};
`endif
        end
    end

    // Next state and all outputs. Every output is forced low while reset is asserted.
    always_comb begin
        state_next = state;
        rd_data    = '0;
        rd_we      = 1'b0;
        jump_addr  = '0;
        jump_en    = 1'b0;
        hold_en    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_addi || is_add) begin
                        rd_data = op1 + op2;
                        rd_we   = 1'b1;
                    end else if (is_sub) begin
                        rd_data = op1 - op2;
                        rd_we   = 1'b1;
                    end else if (is_branch) begin
                        hold_en   = 1'b1;
                        jump_en   = br_taken;
                        jump_addr = br_taken ? br_target : '0;
                    end else if (is_mop) begin
                        hold_en    = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                hold_en = 1'b1;
                busy    = 1'b1;
                if (cnt == '0) state_next = DONE;
            end
            DONE: begin
                rd_data    = result;
                rd_we      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            state_next = IDLE;
            rd_data    = '0;
            rd_we      = 1'b0;
            jump_addr  = '0;
            jump_en    = 1'b0;
            hold_en    = 1'b0;
            busy       = 1'b0;
        end
    end

endmodule

// File: tb/tb_execution_mc.sv
// Testbench for execution_mc: randomized and directed instructions against a
// behavioural RV32IM reference model, with scoreboard queues drained by a monitor.
`timescale 1ns/1ps
module tb_execution_mc;
  localparam int XLEN  = 32;
  localparam int CNT_W = 6;
  localparam int K_NONE = 0;
  localparam int K_ALU  = 1;
  localparam int K_BR   = 2;
  localparam int K_MOP  = 3;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_M   = 7'b0000001;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_addr;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] rd_data;
  logic            rd_we;
  logic [XLEN-1:0] jump_addr;
  logic            jump_en;
  logic            hold_en;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_jump_q[$];

  execution_mc #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .inst_addr(inst_addr),
    .op1(op1), .op2(op2), .rd_data(rd_data), .rd_we(rd_we), .jump_addr(jump_addr),
    .jump_en(jump_en), .hold_en(hold_en), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_addi();
    return {12'd0, 5'd1, 3'b000, 5'd3, 7'b0010011};
  endfunction

  // reference model: architectural result of one instruction
  function automatic void model(input logic [31:0] i, input logic [XLEN-1:0] pc,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                output int kind, output logic [XLEN-1:0] res,
                                output logic taken, output logic [XLEN-1:0] tgt);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic signed [12:0] imm;
    logic [XLEN-1:0] min_v;
    int off;
    opc = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    imm = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    off = int'(imm);
    min_v = {1'b1, {(XLEN-1){1'b0}}};
    kind = K_NONE;
    res = '0;
    taken = 1'b0;
    tgt = '0;
    if (opc == 7'b0010011 && f3 == 3'b000) begin
      kind = K_ALU; res = a + b;
    end else if (opc == OPC_OP && f3 == 3'b000 && f7 == 7'b0000000) begin
      kind = K_ALU; res = a + b;
    end else if (opc == OPC_OP && f3 == 3'b000 && f7 == 7'b0100000) begin
      kind = K_ALU; res = a - b;
    end else if (opc == 7'b1100011) begin
      kind = K_BR;
      case (f3)
        3'b000: taken = (a == b);
        3'b001: taken = (a != b);
        3'b100: taken = ($signed(a) < $signed(b));
        3'b101: taken = ($signed(a) >= $signed(b));
        3'b110: taken = (a < b);
        3'b111: taken = (a >= b);
        default: kind = K_NONE;
      endcase
      if (taken) tgt = pc + off;
    end else if (opc == OPC_OP && f7 == F7_M) begin
      case (f3)
        3'b000: begin kind = K_MOP; res = a * b; end
`ifdef EXEC_MC_DIV_EN
        3'b100: begin
          kind = K_MOP;
          if (b == '0) res = '1;
          else if (a == min_v && b == '1) res = a;
          else res = $signed(a) / $signed(b);
        end
        3'b101: begin kind = K_MOP; res = (b == '0) ? '1 : a / b; end
        3'b110: begin
          kind = K_MOP;
          if (b == '0) res = a;
          else if (a == min_v && b == '1) res = '0;
          else res = $signed(a) % $signed(b);
        end
        3'b111: begin kind = K_MOP; res = (b == '0) ? a : a % b; end
`endif
        default: kind = K_NONE;
      endcase
    end
  endfunction

  // scoreboard monitor: pops an expectation whenever the DUT writes back or jumps
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_we) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_we_unexpected: rd_data %h with no expected write-back", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end
      if (jump_en) begin
        if (exp_jump_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL jump_unexpected: jump_addr %h with no expected branch", jump_addr);
        end else begin
          check("jump_addr", jump_addr, exp_jump_q.pop_front());
        end
      end else begin
        check("jump_addr_zero", jump_addr, '0);
      end
    end
  end

  // driver tasks
  task automatic issue_now(input logic [31:0] i, input logic [XLEN-1:0] pc,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int kind;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] tgt;
    logic taken;
    int hold_cnt;
    int lat;
    logic seen;
    model(i, pc, a, b, kind, res, taken, tgt);
    in_valid = 1'b1; inst = i; inst_addr = pc; op1 = a; op2 = b;
    if (kind == K_ALU || kind == K_MOP) exp_q.push_back(res);
    if (taken) exp_jump_q.push_back(tgt);
    if (kind == K_MOP) begin
      hold_cnt = 0; lat = 0; seen = 1'b0;
      for (int c = 0; c < XLEN + 8 && !seen; c++) begin
        @(negedge clk);
        if (hold_en) hold_cnt++;
        if (c == 0) begin
          check_bit("mop_accept_hold", hold_en, 1'b1);
          check_bit("mop_accept_busy", busy, 1'b0);
        end
        if (rd_we) begin
          seen = 1'b1;
          lat = c;
          check_bit("mop_done_hold", hold_en, 1'b0);
          check_bit("mop_done_busy", busy, 1'b0);
        end
      end
      check_bit("mop_result_seen", seen, 1'b1);
      check_int("mop_latency", lat, XLEN + 1);
      check_int("mop_hold_cycles", hold_cnt, XLEN + 1);
    end else begin
      @(negedge clk);
      check_bit("hold_en", hold_en, kind == K_BR);
      check_bit("busy", busy, 1'b0);
      check_bit("rd_we", rd_we, kind == K_ALU);
      if (kind == K_NONE) check("rd_data_unknown", rd_data, '0);
    end
  endtask

  task automatic issue(input logic [31:0] i, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(posedge clk); #1;
    issue_now(i, pc, a, b);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    in_valid = 1'b0; inst = $urandom; op1 = $urandom; op2 = $urandom;
    @(negedge clk);
    check("idle_flags", {28'd0, rd_we, jump_en, hold_en, busy}, '0);
    check("idle_rd_data", rd_data, '0);
  endtask

  task automatic reset_mid_mul();
    @(posedge clk); #1;
    in_valid = 1'b1; inst = enc_r(F7_M, 3'b000, OPC_OP); op1 = $urandom; op2 = $urandom;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_bit("calc9_busy", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_calc_flags", {28'd0, rd_we, jump_en, hold_en, busy}, '0);
    check("rst_calc_rd_data", rd_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue_now(enc_r(7'h00, 3'b000, OPC_OP), '0, 32'd100, 32'd23);
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(XLEN-1){1'b0}}};
      3: return XLEN'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // main stimulus
  initial begin
    logic [31:0] i;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0] f3;
    rst = 1'b1; in_valid = 1'b0; inst = '0; inst_addr = '0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1; inst = enc_r(7'h00, 3'b000, OPC_OP); op1 = 32'd5; op2 = 32'd7;
    @(negedge clk);
    check("reset_flags", {28'd0, rd_we, jump_en, hold_en, busy}, '0);
    check("reset_rd_data", rd_data, '0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_flags", {28'd0, rd_we, jump_en, hold_en, busy}, '0);

    // directed cases
    issue(enc_r(7'h00, 3'b000, OPC_OP), 32'h0, 32'd5, 32'd7);
    issue(enc_r(7'h20, 3'b000, OPC_OP), 32'h0, 32'd5, 32'd7);
    issue(enc_addi(), 32'h0, 32'hFFFF_FFF0, 32'd16);
    issue(enc_b(3'b001, 13'h1FF8), 32'h100, 32'd1, 32'd2);
    issue(enc_b(3'b001, 13'h1FF8), 32'h100, 32'd2, 32'd2);
    issue(enc_b(3'b100, 13'h0010), 32'h200, 32'hFFFF_FFFF, 32'd1);
    issue(enc_b(3'b110, 13'h0010), 32'h200, 32'hFFFF_FFFF, 32'd1);
    issue(enc_b(3'b010, 13'h0010), 32'h200, 32'd3, 32'd3);
    issue(enc_r(F7_M, 3'b000, OPC_OP), 32'h0, 32'hFFFF_FFFF, 32'd3);
    issue(enc_r(F7_M, 3'b001, OPC_OP), 32'h0, 32'd6, 32'd7);
`ifdef EXEC_MC_DIV_EN
    issue(enc_r(F7_M, 3'b100, OPC_OP), 32'h0, 32'hFFFF_FFF9, 32'd2);
    issue(enc_r(F7_M, 3'b110, OPC_OP), 32'h0, 32'hFFFF_FFF9, 32'd2);
    issue(enc_r(F7_M, 3'b101, OPC_OP), 32'h0, 32'd7, 32'd0);
    issue(enc_r(F7_M, 3'b100, OPC_OP), 32'h0, 32'hFFFF_FFF9, 32'd0);
    issue(enc_r(F7_M, 3'b110, OPC_OP), 32'h0, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(enc_r(F7_M, 3'b100, OPC_OP), 32'h0, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(enc_r(F7_M, 3'b111, OPC_OP), 32'h0, 32'd100, 32'd7);
`else
    issue(enc_r(F7_M, 3'b101, OPC_OP), 32'h0, 32'd9, 32'd3);
    issue(enc_r(F7_M, 3'b110, OPC_OP), 32'h0, 32'd9, 32'd4);
`endif
    idle_cycle();
    reset_mid_mul();
    idle_cycle();

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      a = rand_operand();
      b = rand_operand();
      case ($urandom_range(0, 7))
        0: i = enc_addi();
        1: i = enc_r(7'h00, 3'b000, OPC_OP);
        2: i = enc_r(7'h20, 3'b000, OPC_OP);
        3, 4: begin
          i = $urandom;
          i[6:0] = 7'b1100011;
          if ($urandom_range(0, 2) == 0) b = a;
        end
        5: begin
          f3 = 3'($urandom_range(0, 7));
          i = enc_r(F7_M, f3, OPC_OP);
        end
        6: i = enc_r(F7_M, 3'b000, OPC_OP);
        default: i = $urandom;
      endcase
      issue(i, $urandom, a, b);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    check_int("exp_q_drained", exp_q.size(), 0);
    check_int("exp_jump_q_drained", exp_jump_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
